// File: rtl/cnn_result_collector.sv
// cnn_result_collector: groups every N_CLASS fp32 score words from the CNN core into one
// frame. For each frame it computes the argmax class and the max score, and queues the
// result in a small FIFO that the host drains over a valid/ready handshake.
// Optional feature: define CNN_COLLECT_STAT_EN to add a 16-bit frame_cnt output that counts
// frames pushed into the FIFO.
module cnn_result_collector #(
  parameter int unsigned N_CLASS    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_MAX    = 8,
  localparam int unsigned CLS_W     = $clog2(N_CLASS),
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CLS_W-1:0] out_class,
  output logic [31:0]      out_max,
  output logic             drop_flag,
  output logic             gap_err,
  output logic [CNT_W-1:0] fifo_count
`ifdef CNN_COLLECT_STAT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned GAP_W = $clog2(GAP_MAX);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e             state_q, state_d;
  logic [CLS_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [31:0]        max_q, max_d;
  logic [CLS_W-1:0]   cls_q, cls_d;
  logic               gap_err_q, gap_err_d;

  logic [CLS_W-1:0]   word_idx;
  logic               take;
  logic [CLS_W-1:0]   frame_cls;
  logic [31:0]        frame_max;
  logic               push;

  logic [CLS_W-1:0]   mem_cls [FIFO_DEPTH];
  logic [31:0]        mem_max [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic               drop_q;

  // Map fp32 bits to an unsigned key whose integer order matches the score order.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  // Running-max datapath: word 0 seeds, later words replace only on a strictly greater key.
  always_comb begin
    word_idx  = (state_q == StIdle) ? '0 : idx_q;
    take      = (word_idx == '0) || (order_key(in_data) > order_key(max_q));
    frame_cls = take ? word_idx : cls_q;
    frame_max = take ? in_data : max_q;
    push      = in_valid && (word_idx == CLS_W'(N_CLASS - 1));
  end

  // Frame FSM next state: word indexing and gap timeout.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    max_d     = max_q;
    cls_d     = cls_q;
    gap_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          max_d = frame_max;
          cls_d = frame_cls;
          gap_d = '0;
          if (!push) begin
            state_d = StCollect;
            idx_d   = CLS_W'(1);
          end
        end
      end
      StCollect: begin
        if (in_valid) begin
          max_d = frame_max;
          cls_d = frame_cls;
          gap_d = '0;
          if (push) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CLS_W'(1);
          end
        end else if (gap_q == GAP_W'(GAP_MAX - 1)) begin
          // This idle cycle is the GAP_MAX-th in a row: abandon the partial frame.
          state_d   = StIdle;
          idx_d     = '0;
          gap_d     = '0;
          gap_err_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  // Frame FSM and running-max registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      gap_q     <= '0;
      max_q     <= '0;
      cls_q     <= '0;
      gap_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      max_q     <= max_d;
      cls_q     <= cls_d;
      gap_err_q <= gap_err_d;
    end
  end

  // FIFO control: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    out_valid = (count_q != '0);
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = out_valid && out_ready;
    wr_en     = push && (!full || pop);
    count_d   = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_cls[wr_ptr_q] <= frame_cls;
      mem_max[wr_ptr_q] <= frame_max;
    end
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !wr_en) begin
        drop_q <= 1'b1;
      end
    end
  end

  // Head outputs are forced to zero while the FIFO is empty.
  always_comb begin
    out_class  = out_valid ? mem_cls[rd_ptr_q] : '0;
    out_max    = out_valid ? mem_max[rd_ptr_q] : '0;
    drop_flag  = drop_q;
    gap_err    = gap_err_q;
    fifo_count = count_q;
  end

`ifdef CNN_COLLECT_STAT_EN
  logic [15:0] frame_cnt_q;

  // Count frames actually stored; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (wr_en) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_cnn_result_collector.sv
// Self-checking bench for cnn_result_collector with a queue-based reference model.
module tb_cnn_result_collector;

  localparam int N_CLASS    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_MAX    = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [1:0]  out_class;
  logic [31:0] out_max;
  logic        drop_flag;
  logic        gap_err;
  logic [2:0]  fifo_count;
`ifdef CNN_COLLECT_STAT_EN
  logic [15:0] frame_cnt;
`endif

  cnn_result_collector #(
    .N_CLASS   (N_CLASS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_MAX   (GAP_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_class (out_class),
    .out_max   (out_max),
    .drop_flag (drop_flag),
    .gap_err   (gap_err),
    .fifo_count(fifo_count)
`ifdef CNN_COLLECT_STAT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Reference model state
  logic [1:0]  q_cls[$];
  logic [31:0] q_max[$];
  logic [31:0] words[$];
  int          m_idle;
  bit          m_drop;
  bit          m_gap;
  int unsigned m_frames;

  function automatic logic [31:0] key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  // Argmax over the collected words; first index wins ties.
  function automatic void ref_frame(output logic [1:0] c, output logic [31:0] m);
    int best = 0;
    for (int i = 1; i < N_CLASS; i++) begin
      if (key(words[i]) > key(words[best])) best = i;
    end
    c = 2'(best);
    m = words[best];
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FC0_0000;
      3: return 32'hFFC0_0000;
      4: return 32'h3F80_0000;
      5: return 32'hBF80_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic model_reset();
    q_cls.delete();
    q_max.delete();
    words.delete();
    m_idle   = 0;
    m_drop   = 0;
    m_gap    = 0;
    m_frames = 0;
  endtask

  // Apply one cycle of inputs, advance the model across the edge, sample 1 unit after it.
  task automatic drive(input bit v, input logic [31:0] d, input bit rdy);
    logic [1:0]  c;
    logic [31:0] m;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    if (q_cls.size() != 0 && rdy) begin
      void'(q_cls.pop_front());
      void'(q_max.pop_front());
    end
    m_gap = 0;
    if (v) begin
      words.push_back(d);
      m_idle = 0;
      if (words.size() == N_CLASS) begin
        ref_frame(c, m);
        if (q_cls.size() < FIFO_DEPTH) begin
          q_cls.push_back(c);
          q_max.push_back(m);
          m_frames++;
        end else begin
          m_drop = 1;
        end
        words.delete();
      end
    end else if (words.size() != 0) begin
      m_idle++;
      if (m_idle == GAP_MAX) begin
        words.delete();
        m_idle = 0;
        m_gap  = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; in_data = '0; out_ready = 0; rst = 0;
    #2 rst = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_cmp++; if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", drop_flag); end
    n_cmp++; if (gap_err !== 1'b0) begin n_fail++; $display("FAIL reset_gap: got %b expected 0", gap_err); end
    n_cmp++; if (out_max !== 32'h0 || out_class !== 2'd0) begin
      n_fail++; $display("FAIL reset_head: got %0d/%h expected 0/0", out_class, out_max);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    drive(1, 32'h3F00_0000, 1);
    drive(1, 32'h3E80_0000, 1);
    drive(1, 32'h3E00_0000, 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_class !== 2'd0 || out_max !== 32'h3F00_0000) begin
      n_fail++; $display("FAIL basic_head: got %0d/%h expected 0/3f000000", out_class, out_max);
    end
    n_cmp++; if (fifo_count !== 3'(q_cls.size())) begin
      n_fail++; $display("FAIL basic_count: got %0d expected %0d", fifo_count, q_cls.size());
    end
    drive(0, 32'h0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: got %b expected 0", out_valid); end
  endtask

  task automatic test_order();
    logic [31:0] w [4][3];
    logic [1:0]  ec [4];
    logic [31:0] em [4];
    w[0] = '{32'hBF80_0000, 32'hC000_0000, 32'h0000_0000}; ec[0] = 2; em[0] = 32'h0000_0000;
    w[1] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000}; ec[1] = 1; em[1] = 32'h0000_0000;
    w[2] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}; ec[2] = 0; em[2] = 32'h3F80_0000;
    w[3] = '{32'h4000_0000, 32'h4040_0000, 32'h4040_0000}; ec[3] = 1; em[3] = 32'h4040_0000;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 3; i++) drive(1, w[f][i], 0);
      n_cmp++; if (out_class !== ec[f] || out_max !== em[f]) begin
        n_fail++; $display("FAIL order_f%0d: got %0d/%h expected %0d/%h", f, out_class, out_max, ec[f], em[f]);
      end
      n_cmp++; if (out_class !== q_cls[0] || out_max !== q_max[0]) begin
        n_fail++; $display("FAIL order_model_f%0d: got %0d/%h expected %0d/%h", f, out_class, out_max, q_cls[0], q_max[0]);
      end
      drive(0, 32'h0, 1);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_pop_f%0d: got %b expected 0", f, out_valid); end
    end
  endtask

  task automatic test_overflow();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 3; i++) drive(1, rnd_word(), 0);
    end
    n_cmp++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    n_cmp++; if (drop_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_drop: got %b expected 1", drop_flag); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_class !== q_cls[0] || out_max !== q_max[0]) begin
        n_fail++; $display("FAIL ovf_drain%0d: got %b %0d/%h expected 1 %0d/%h", k, out_valid, out_class, out_max, q_cls[0], q_max[0]);
      end
      drive(0, 32'h0, 1);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_gap();
    drive(1, rnd_word(), 0);
    drive(1, rnd_word(), 0);
    for (int i = 0; i < GAP_MAX; i++) begin
      drive(0, 32'h0, 0);
      if (i == GAP_MAX - 2) begin
        n_cmp++; if (gap_err !== 1'b0) begin n_fail++; $display("FAIL gap_early: got %b expected 0", gap_err); end
      end
    end
    n_cmp++; if (gap_err !== 1'b1) begin n_fail++; $display("FAIL gap_pulse: got %b expected 1", gap_err); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL gap_count: got %0d expected 0", fifo_count); end
    drive(0, 32'h0, 0);
    n_cmp++; if (gap_err !== 1'b0) begin n_fail++; $display("FAIL gap_width: got %b expected 0", gap_err); end
    for (int i = 0; i < 3; i++) drive(1, rnd_word(), 0);
    n_cmp++; if (fifo_count !== 3'd1 || out_class !== q_cls[0] || out_max !== q_max[0]) begin
      n_fail++; $display("FAIL gap_next: got %0d %0d/%h expected 1 %0d/%h", fifo_count, out_class, out_max, q_cls[0], q_max[0]);
    end
    drive(0, 32'h0, 1);
    drive(1, rnd_word(), 0);
    drive(1, rnd_word(), 0);
    for (int i = 0; i < GAP_MAX - 1; i++) drive(0, 32'h0, 0);
    drive(1, rnd_word(), 0);
    n_cmp++; if (fifo_count !== 3'd1 || gap_err !== 1'b0) begin
      n_fail++; $display("FAIL gap_edge: got count %0d gap %b expected 1 0", fifo_count, gap_err);
    end
    n_cmp++; if (out_class !== q_cls[0] || out_max !== q_max[0]) begin
      n_fail++; $display("FAIL gap_edge_head: got %0d/%h expected %0d/%h", out_class, out_max, q_cls[0], q_max[0]);
    end
    drive(0, 32'h0, 1);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) drive(1, rnd_word(), 0);
    drive(1, rnd_word(), 0);
    @(negedge clk);
    in_valid = 0;
    #2 rst = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL mrst_fifo: got %b %0d expected 0 0", out_valid, fifo_count);
    end
    n_cmp++; if (drop_flag !== 1'b0 || out_class !== 2'd0 || out_max !== 32'h0) begin
      n_fail++; $display("FAIL mrst_out: got %b %0d/%h expected 0 0/0", drop_flag, out_class, out_max);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) drive(1, rnd_word(), 0);
    n_cmp++; if (fifo_count !== 3'd1 || out_class !== q_cls[0] || out_max !== q_max[0]) begin
      n_fail++; $display("FAIL mrst_frame: got %0d %0d/%h expected 1 %0d/%h", fifo_count, out_class, out_max, q_cls[0], q_max[0]);
    end
    drive(0, 32'h0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_pop: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < FIFO_DEPTH; f++) begin
      for (int i = 0; i < 3; i++) drive(1, rnd_word(), 0);
    end
    drive(1, rnd_word(), 0);
    drive(1, rnd_word(), 0);
    drive(1, rnd_word(), 1);
    n_cmp++; if (fifo_count !== 3'd4 || drop_flag !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full: got %0d %b expected 4 0", fifo_count, drop_flag);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_class !== q_cls[0] || out_max !== q_max[0]) begin
        n_fail++; $display("FAIL b2b_drain%0d: got %0d/%h expected %0d/%h", k, out_class, out_max, q_cls[0], q_max[0]);
      end
      drive(0, 32'h0, 1);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    int idle_run = 0;
    bit v;
    for (int n = 0; n < 800; n++) begin
      if (idle_run > 0) begin
        v = 0;
        idle_run--;
      end else if ($urandom_range(0, 30) == 0) begin
        v = 0;
        idle_run = $urandom_range(5, 9);
      end else begin
        v = ($urandom_range(0, 9) < 7);
      end
      drive(v, rnd_word(), ($urandom_range(0, 9) < 5));
      n_cmp++; if (out_valid !== (q_cls.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, out_valid, q_cls.size() != 0);
      end
      n_cmp++; if (fifo_count !== 3'(q_cls.size())) begin
        n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, fifo_count, q_cls.size());
      end
      n_cmp++; if (drop_flag !== m_drop || gap_err !== m_gap) begin
        n_fail++; $display("FAIL rnd_flags@%0d: got %b%b expected %b%b", n, drop_flag, gap_err, m_drop, m_gap);
      end
      if (q_cls.size() != 0) begin
        n_cmp++; if (out_class !== q_cls[0] || out_max !== q_max[0]) begin
          n_fail++; $display("FAIL rnd_head@%0d: got %0d/%h expected %0d/%h", n, out_class, out_max, q_cls[0], q_max[0]);
        end
      end
`ifdef CNN_COLLECT_STAT_EN
      n_cmp++; if (frame_cnt !== 16'(m_frames)) begin
        n_fail++; $display("FAIL rnd_fcnt@%0d: got %0d expected %0d", n, frame_cnt, 16'(m_frames));
      end
`endif
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_order();
    test_overflow();
    test_gap();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
